// File: rtl/fifo_drain.sv
// Read-side drain for the FIFO pointer controller: issues rd strobes, captures
// synchronous-RAM data into a 2-entry buffer and presents it as a valid/ready stream.
module fifo_drain #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  output logic              rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  word_count
);

  logic [DATA_W-1:0] slot1;
  logic              rd_d1;
  logic              pop;
  logic              capture;
  logic [2:0]        pending;

  assign out_valid = (occupancy != 2'd0);

  // pending counts buffered plus in-flight words left after this cycle's pop,
  // so a new read is only issued when a slot is guaranteed on arrival.
  always_comb begin
    pop     = out_valid && out_ready;
    capture = rd_d1 && !flush;
    pending = {1'b0, occupancy} + {2'b00, rd_d1} - {2'b00, pop};
    rd      = !rst && !flush && !empty && (pending < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy  <= '0;
      out_data   <= '0;
      slot1      <= '0;
      rd_d1      <= 1'b0;
      word_count <= '0;
    end else begin
      rd_d1 <= rd;
      if (flush) begin
        occupancy <= '0;
      end else begin
        if (pop) word_count <= word_count + CNT_W'(1);
        // out_data is the head slot; slot1 only matters while two words are held.
        if (capture && pop) begin
          if (occupancy == 2'd2) begin
            out_data <= slot1;
            slot1    <= mem_rdata;
          end else begin
            out_data <= mem_rdata;
          end
        end else if (capture) begin
          if (occupancy == 2'd0) out_data <= mem_rdata;
          else                   slot1    <= mem_rdata;
        end else if (pop) begin
          out_data <= slot1;
        end
        occupancy <= occupancy + {1'b0, capture} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboard bench for fifo_drain: a queue-based FIFO/RAM model feeds the DUT,
// words read are queued as expected output and checked by a negedge monitor.
module tb_fifo_drain;

  localparam int DATA_W   = 8;
  localparam int CNT_W    = 4;
  localparam int CNT_MOD  = 1 << CNT_W;
  localparam int MEM_SZ   = 1024;
  localparam int MAX_CYC  = 5000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              empty;
  logic              rd;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  word_count;

  fifo_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .empty(empty), .rd(rd), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .occupancy(occupancy), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // FIFO contents: stimulus owns wr_ptr and mem, the responder owns rd_ptr.
  logic [DATA_W-1:0] mem [MEM_SZ];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (rd_ptr == wr_ptr);

  // Scoreboard: words read from the FIFO but not yet delivered (in-flight included).
  logic [DATA_W-1:0] exp_q [$];
  int  inflight_m = 0;
  int  cnt_m      = 0;
  bit  started    = 0;
  bit  after_rst  = 0;
  bit  ev_rd = 0, ev_flush = 0, ev_rst = 1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Directed-check requests from stimulus, serviced by the monitor.
  int req_seq = 0, done_seq = 0, dir_code = 0, dir_val = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp_v, exp_v, $time);
    end
  endtask

  // Responder: models the RAM read latency and the controller's reset/flush effects.
  always @(posedge clk) begin
    if (ev_rst) begin
      exp_q.delete();
      inflight_m = 0;
      cnt_m      = 0;
      rd_ptr     = wr_ptr;
      after_rst  = 1;
      started    = 1;
      mem_rdata <= DATA_W'($urandom);
    end else begin
      after_rst = 0;
      if (ev_flush) begin
        exp_q.delete();
        inflight_m = 0;
      end
      if (ev_rd) begin
        exp_q.push_back(mem[rd_ptr]);
        mem_rdata <= mem[rd_ptr];
        rd_ptr++;
        inflight_m = 1;
      end else begin
        mem_rdata <= DATA_W'($urandom);
        inflight_m = 0;
      end
    end
  end

  // Monitor: compares every cycle, pops the scoreboard on each delivered word.
  always @(negedge clk) begin
    int  occ_m;
    bit  pop_m;
    bit  rd_m;
    cyc++;
    if (cyc > MAX_CYC) begin
      errors++;
      $display("FAIL watchdog: got %0d cycles, expected at most %0d", cyc, MAX_CYC);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
    if (started) begin
      occ_m = exp_q.size() - inflight_m;
      pop_m = (occ_m != 0) && out_ready;
      rd_m  = !rst && !flush && (rd_ptr != wr_ptr) && ((exp_q.size() - int'(pop_m)) < 2);
      chk("rd", int'(rd), int'(rd_m));
      chk("occupancy", int'(occupancy), occ_m);
      chk("out_valid", int'(out_valid), int'(occ_m != 0));
      chk("word_count", int'(word_count), cnt_m);
      if (occ_m != 0) chk("out_data", int'(out_data), int'(exp_q[0]));
      if (after_rst)  chk("reset_out_data", int'(out_data), 0);
      if (req_seq != done_seq) begin
        case (dir_code)
          0:       chk("dir_word_count", int'(word_count), dir_val);
          1:       chk("dir_occupancy", int'(occupancy), dir_val);
          default: chk("dir_head_word", int'(out_data), dir_val);
        endcase
        done_seq = req_seq;
      end
      if (pop_m && !flush && !rst) begin
        void'(exp_q.pop_front());
        cnt_m = (cnt_m + 1) % CNT_MOD;
      end
      ev_rd    = rd_m;
      ev_flush = flush;
      ev_rst   = rst;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    if (wr_ptr < MEM_SZ) begin
      mem[wr_ptr] = v;
      wr_ptr++;
    end
  endtask

  task automatic req(input int code, input int val);
    dir_code = code;
    dir_val  = val;
    req_seq++;
    tick(1);
  endtask

  initial begin
    logic [DATA_W-1:0] w0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;

    // Three pre-loaded words streamed with the sink always ready.
    push(8'h11); push(8'h22); push(8'h33);
    out_ready = 1'b1;
    tick(8);
    req(0, 3);

    // Ten words against a stalled sink, then released.
    out_ready = 1'b0;
    w0 = DATA_W'($urandom);
    push(w0);
    for (int i = 1; i < 10; i++) push(DATA_W'($urandom));
    tick(8);
    req(1, 2);
    req(2, int'(w0));
    out_ready = 1'b1;
    tick(16);
    req(0, 13);

    // Sixteen words with out_ready alternating.
    for (int i = 0; i < 16; i++) push(DATA_W'($urandom));
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 2 == 0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(6);
    req(0, 13);

    // Flush with one word buffered and one in flight; the next FIFO word follows.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(DATA_W'($urandom));
    tick(2);
    req(1, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    req(1, 0);
    out_ready = 1'b1;
    tick(10);
    req(0, 0);

    // Reset mid-burst while one word is buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DATA_W'($urandom));
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req(0, 0);

    // Seventeen deliveries wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) push(DATA_W'($urandom));
    out_ready = 1'b1;
    tick(25);
    req(0, 1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        int n;
        n = int'($urandom_range(3, 1));
        for (int k = 0; k < n; k++) push(DATA_W'($urandom));
      end
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(24) == 0);
      rst       = ($urandom_range(199) == 0);
      tick(1);
    end
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
